gbt_rx_frameclk_phalgnr_ctrl: RTL

//  Dynamic-phase-shift sequencer for the RX frame-clock phase aligner PLL (120 MHz ref, 720 MHz VCO, 40 MHz C0).

---
 rtl/gbt_rx_frameclk_phalgnr_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/gbt_rx_frameclk_phalgnr_ctrl.sv
// Dynamic-phase-shift sequencer for the RX frame-clock phase aligner PLL (scanclk domain).
// Optional absolute phase tracking output enabled by defining PHALGNR_PHASE_TRACK_EN.
module gbt_rx_frameclk_phalgnr_ctrl #(
    parameter int         STEP_W       = 8,
    parameter logic [4:0] CNTSEL_VAL   = 5'd0,
    parameter int         PHASE_EN_CYC = 2,
    parameter int         TIMEOUT_CYC  = 1023
`ifdef PHALGNR_PHASE_TRACK_EN
    , parameter int       STEPS_PER_PER = 144
`endif
) (
    input  logic              scanclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              shift_req,
    input  logic [STEP_W-1:0] shift_steps,
    input  logic              shift_dir,
    output logic              busy,
    output logic              req_drop,
    output logic              done,
    output logic              err,
    output logic [STEP_W-1:0] steps_done,
    output logic              phase_en,
    output logic              updn,
    output logic [4:0]        cntsel,
    input  logic              phase_done
`ifdef PHALGNR_PHASE_TRACK_EN
    , output logic [7:0]      phase_pos
`endif
);

    localparam int EN_W  = $clog2(PHASE_EN_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_WAIT_LO,
        S_WAIT_HI,
        S_NEXT,
        S_FIN
    } state_t;

    state_t            state, state_n;
    logic              lock_meta, lock_sync;
    logic [STEP_W-1:0] remaining, remaining_n, steps_done_n;
    logic [EN_W-1:0]   en_cnt, en_cnt_n;
    logic [TMO_W-1:0]  tmo, tmo_n;
    logic              phase_en_n, updn_n, done_n, err_n, req_drop_n;
    logic              tmo_hit;

    assign busy    = (state != S_IDLE) | ~lock_sync;
    assign tmo_hit = (tmo == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge scanclk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

    always_comb begin
        state_n      = state;
        remaining_n  = remaining;
        steps_done_n = steps_done;
        en_cnt_n     = en_cnt;
        tmo_n        = tmo;
        phase_en_n   = phase_en;
        updn_n       = updn;
        err_n        = err;
        req_drop_n   = shift_req & busy;
        done_n       = 1'b0;

        case (state)
            S_IDLE: begin
                if (shift_req && !busy) begin
                    remaining_n  = shift_steps;
                    steps_done_n = '0;
                    err_n        = 1'b0;
                    updn_n       = shift_dir;
                    if (shift_steps == '0) begin
                        state_n = S_FIN;
                    end else begin
                        state_n    = S_ASSERT;
                        phase_en_n = 1'b1;
                        en_cnt_n   = '0;
                    end
                end
            end
            S_ASSERT: begin
                if (en_cnt == EN_W'(PHASE_EN_CYC - 1)) begin
                    phase_en_n = 1'b0;
                    state_n    = S_WAIT_LO;
                    tmo_n      = '0;
                end else begin
                    en_cnt_n = en_cnt + 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!phase_done) begin
                    state_n = S_WAIT_HI;
                    tmo_n   = '0;
                end else if (tmo_hit) begin
                    err_n   = 1'b1;
                    state_n = S_FIN;
                end else begin
                    tmo_n = tmo + 1'b1;
                end
            end
            S_WAIT_HI: begin
                if (phase_done) begin
                    state_n = S_NEXT;
                end else if (tmo_hit) begin
                    err_n   = 1'b1;
                    state_n = S_FIN;
                end else begin
                    tmo_n = tmo + 1'b1;
                end
            end
            S_NEXT: begin
                steps_done_n = steps_done + 1'b1;
                remaining_n  = remaining - 1'b1;
                if (remaining == STEP_W'(1)) begin
                    state_n = S_FIN;
                end else begin
                    state_n    = S_ASSERT;
                    phase_en_n = 1'b1;
                    en_cnt_n   = '0;
                end
            end
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Lock loss overrides any in-flight step; a step still in NEXT is not credited.
        if (!lock_sync && state != S_IDLE && state != S_FIN) begin
            state_n      = S_FIN;
            phase_en_n   = 1'b0;
            err_n        = 1'b1;
            steps_done_n = steps_done;
            remaining_n  = remaining;
        end

        done_n = (state_n == S_FIN);
    end

    always_ff @(posedge scanclk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            remaining  <= '0;
            steps_done <= '0;
            en_cnt     <= '0;
            tmo        <= '0;
            phase_en   <= 1'b0;
            updn       <= 1'b0;
            cntsel     <= CNTSEL_VAL;
            done       <= 1'b0;
            req_drop   <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            remaining  <= remaining_n;
            steps_done <= steps_done_n;
            en_cnt     <= en_cnt_n;
            tmo        <= tmo_n;
            phase_en   <= phase_en_n;
            updn       <= updn_n;
            cntsel     <= CNTSEL_VAL;
            done       <= done_n;
            req_drop   <= req_drop_n;
            err        <= err_n;
        end
    end

`ifdef PHALGNR_PHASE_TRACK_EN
    logic [7:0] pos_n;

    // A relocked PLL restarts at zero phase, so position is held at 0 while unlocked.
    always_comb begin
        pos_n = phase_pos;
        if (!lock_sync) begin
            pos_n = '0;
        end else if (state == S_NEXT) begin
            if (updn) begin
                pos_n = (phase_pos == 8'(STEPS_PER_PER - 1)) ? 8'd0 : phase_pos + 8'd1;
            end else begin
                pos_n = (phase_pos == 8'd0) ? 8'(STEPS_PER_PER - 1) : phase_pos - 8'd1;
            end
        end
    end

    always_ff @(posedge scanclk or posedge rst) begin
        if (rst) begin
            phase_pos <= '0;
        end else begin
            phase_pos <= pos_n;
        end
    end
`else
    // Phase tracking not built: no position state.
`endif

endmodule
